// File: rtl/lcd_frame_scheduler.sv
// Purpose: paces full-screen SSD1963 refreshes; launches LCD draw + framebuffer reader, swaps buffers at frame edges.
// Latency: tick (controller idle) -> wr_lcd/reader_start/swap_ack one cycle later; timeout_err shows in the abort cycle.
// Backpressure: frame_sync low holds the launch; ticks that find a frame in flight or pending are counted, never queued.
module lcd_frame_scheduler #(
    parameter int FRAME_PERIOD = 3333333,
    parameter int TIMEOUT      = 20000000,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        dvsr_cfg,
    input  logic              swap_req,
    input  logic [ADDR_W-1:0] back_base,
    input  logic              err_clr,
    input  logic              frame_sync,
    output logic              wr_lcd,
    output logic [7:0]        dvsr,
    output logic              reader_start,
    output logic [ADDR_W-1:0] front_base,
    output logic              swap_ack,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic [15:0]       skip_count,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(FRAME_PERIOD);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_WAIT_READY,
        S_LAUNCH,
        S_WAIT_START,
        S_DRAWING
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  period_cnt;
    logic [WD_W-1:0]   watchdog;
    logic              tick;
    logic              wd_last;
    logic              launch_go;
    logic              timeout_hit;
    logic              frame_done;
    logic              skip_hit;
    logic              err_q;
    logic              swap_pending;
    logic [ADDR_W-1:0] swap_addr;
    logic              swap_apply;
    logic [ADDR_W-1:0] swap_src;

    assign tick      = enable && (period_cnt == CNT_LAST);
    assign wd_last   = (watchdog == WD_LAST);
    assign launch_go = (next_state == S_LAUNCH);

    // A tick is lost whenever a frame is pending (WAIT_READY) or already in flight.
    assign skip_hit = tick && ((state == S_WAIT_READY) || (state == S_LAUNCH) ||
                               (state == S_WAIT_START) || (state == S_DRAWING));

    // A request arriving in the launch-decision cycle is honoured right away, with its newest address,
    // so the reader and the LCD always start on one consistent buffer.
    assign swap_apply = swap_pending || swap_req;
    assign swap_src   = swap_req ? back_base : swap_addr;

    // Sticky flag plus the live abort, so the flag is visible in the abort cycle itself.
    assign timeout_err = err_q || timeout_hit;

    // Free-running frame period counter, parked at zero while scheduling is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= '0;
        else if (!enable || tick)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + CNT_W'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; enable only takes effect between frames, never mid-frame.
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable)
                    next_state = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!enable)
                    next_state = S_IDLE;
                else if (tick)
                    next_state = frame_sync ? S_LAUNCH : S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (frame_sync)
                    next_state = S_LAUNCH;
                else if (!enable)
                    next_state = S_IDLE;
            end
            S_LAUNCH: begin
                next_state = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!frame_sync) begin
                    next_state = S_DRAWING;
                end else if (wd_last) begin
                    timeout_hit = 1'b1;
                    next_state  = S_WAIT_TICK;
                end
            end
            S_DRAWING: begin
                if (frame_sync) begin
                    frame_done = 1'b1;
                    next_state = enable ? S_WAIT_TICK : S_IDLE;
                end else if (wd_last) begin
                    timeout_hit = 1'b1;
                    next_state  = S_WAIT_TICK;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Per-phase watchdog: restarts at launch and again when the controller starts drawing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            watchdog <= '0;
        else if ((state == S_WAIT_START && frame_sync) || state == S_DRAWING)
            watchdog <= watchdog + WD_W'(1);
        else
            watchdog <= '0;
    end

    // Launch pulses and busy, registered so they appear together in the LAUNCH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_lcd       <= 1'b0;
            reader_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            wr_lcd       <= launch_go;
            reader_start <= launch_go;
            busy         <= (next_state == S_LAUNCH) || (next_state == S_WAIT_START) ||
                            (next_state == S_DRAWING);
        end
    end

    // Divisor is sampled once per frame, clamped to the controller's minimum of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dvsr <= 8'd4;
        else if (launch_go)
            dvsr <= (dvsr_cfg < 8'd2) ? 8'd2 : dvsr_cfg;
    end

    // Swap latch and front buffer; a request in the LAUNCH cycle itself waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_pending <= 1'b0;
            swap_addr    <= '0;
            front_base   <= '0;
            swap_ack     <= 1'b0;
        end else if (launch_go) begin
            swap_pending <= 1'b0;
            swap_ack     <= swap_apply;
            if (swap_apply)
                front_base <= swap_src;
        end else begin
            swap_ack <= 1'b0;
            if (swap_req) begin
                swap_pending <= 1'b1;
                swap_addr    <= back_base;
            end
        end
    end

    // Completed frames wrap; skipped ticks saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
            skip_count  <= '0;
        end else begin
            if (frame_done)
                frame_count <= frame_count + 16'd1;
            if (skip_hit && skip_count != 16'hFFFF)
                skip_count <= skip_count + 16'd1;
        end
    end

    // Sticky watchdog flag; a new abort beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (timeout_hit)
            err_q <= 1'b1;
        else if (err_clr)
            err_q <= 1'b0;
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Bench for lcd_frame_scheduler: directed scenarios with hand-computed cycle positions.
// Instance A: FRAME_PERIOD=100, TIMEOUT=50; instance B: long watchdog so 150-cycle draws can overrun the period.
// Cycle k of a scenario is the negedge after the k-th posedge following the enable assertion.
`timescale 1ns/1ps
module tb_lcd_frame_scheduler;
    localparam int FP   = 100;
    localparam int TO   = 50;
    localparam int TO_B = 400;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          enable_b = 1'b0;
    logic          swap_req = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    dvsr_cfg = 8'd4;
    logic [AW-1:0] back_base = '0;
    logic          frame_sync;
    logic          frame_sync_b;

    logic          wr_lcd, reader_start, swap_ack, busy, timeout_err;
    logic [7:0]    dvsr;
    logic [AW-1:0] front_base;
    logic [15:0]   frame_count, skip_count;

    logic          b_wr_lcd, b_reader_start, b_swap_ack, b_busy, b_timeout_err;
    logic [7:0]    b_dvsr;
    logic [AW-1:0] b_front_base;
    logic [15:0]   b_frame_count, b_skip_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_frame_scheduler #(.FRAME_PERIOD(FP), .TIMEOUT(TO), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .dvsr_cfg(dvsr_cfg), .swap_req(swap_req),
        .back_base(back_base), .err_clr(err_clr), .frame_sync(frame_sync),
        .wr_lcd(wr_lcd), .dvsr(dvsr), .reader_start(reader_start), .front_base(front_base),
        .swap_ack(swap_ack), .busy(busy), .frame_count(frame_count), .skip_count(skip_count),
        .timeout_err(timeout_err)
    );

    lcd_frame_scheduler #(.FRAME_PERIOD(FP), .TIMEOUT(TO_B), .ADDR_W(AW)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .dvsr_cfg(dvsr_cfg), .swap_req(swap_req),
        .back_base(back_base), .err_clr(err_clr), .frame_sync(frame_sync_b),
        .wr_lcd(b_wr_lcd), .dvsr(b_dvsr), .reader_start(b_reader_start), .front_base(b_front_base),
        .swap_ack(b_swap_ack), .busy(b_busy), .frame_count(b_frame_count), .skip_count(b_skip_count),
        .timeout_err(b_timeout_err)
    );

    // LCD model A: frame_sync drops 3 cycles after wr_lcd and rises 40 cycles later.
    bit ma_stall = 1'b0;
    bit ma_low   = 1'b0;
    bit ma_act;
    bit ma_sync;
    int ma_t;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ma_act  <= 1'b0;
            ma_sync <= 1'b1;
            ma_t    <= 0;
        end else if (wr_lcd === 1'b1) begin
            ma_act <= 1'b1;
            ma_t   <= 1;
        end else if (ma_act) begin
            ma_t <= ma_t + 1;
            if (ma_t == 3 && !ma_stall)
                ma_sync <= 1'b0;
            if (ma_t == 43) begin
                ma_sync <= 1'b1;
                ma_act  <= 1'b0;
            end
        end
    end
    assign frame_sync = ma_sync && !ma_low;

    // LCD model B: 150-cycle draw, longer than the frame period.
    bit mb_act;
    bit mb_sync;
    int mb_t;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            mb_act  <= 1'b0;
            mb_sync <= 1'b1;
            mb_t    <= 0;
        end else if (b_wr_lcd === 1'b1) begin
            mb_act <= 1'b1;
            mb_t   <= 1;
        end else if (mb_act) begin
            mb_t <= mb_t + 1;
            if (mb_t == 3)
                mb_sync <= 1'b0;
            if (mb_t == 153) begin
                mb_sync <= 1'b1;
                mb_act  <= 1'b0;
            end
        end
    end
    assign frame_sync_b = mb_sync;

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; enable_b = 1'b0; swap_req = 1'b0; err_clr = 1'b0;
        dvsr_cfg = 8'd4; back_base = '0; ma_stall = 1'b0; ma_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (wr_lcd !== 1'b0) begin n_err++; $display("FAIL reset_wr_lcd: got %b want 0", wr_lcd); end
        n_vec++; if (reader_start !== 1'b0) begin n_err++; $display("FAIL reset_reader_start: got %b want 0", reader_start); end
        n_vec++; if (swap_ack !== 1'b0) begin n_err++; $display("FAIL reset_swap_ack: got %b want 0", swap_ack); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_vec++; if (front_base !== 32'h0) begin n_err++; $display("FAIL reset_front_base: got %h want 0", front_base); end
        n_vec++; if (dvsr !== 8'd4) begin n_err++; $display("FAIL reset_dvsr: got %0d want 4", dvsr); end
        n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_vec++; if (skip_count !== 16'd0) begin n_err++; $display("FAIL reset_skip_count: got %0d want 0", skip_count); end
        n_vec++; if ({b_wr_lcd, b_reader_start, b_swap_ack, b_busy} !== 4'b0) begin n_err++; $display("FAIL reset_b_pulses: got %b want 0000", {b_wr_lcd, b_reader_start, b_swap_ack, b_busy}); end
        n_vec++; if (b_front_base !== 32'h0 || b_dvsr !== 8'd4) begin n_err++; $display("FAIL reset_b_regs: got base %h dvsr %0d want 0/4", b_front_base, b_dvsr); end
        do_reset();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_normal();
        int npulse;
        int bad_rs;
        do_reset();
        npulse = 0; bad_rs = 0;
        dvsr_cfg = 8'd6; enable = 1'b1;
        for (int k = 1; k <= 560; k++) begin
            @(negedge clk);
            if (reader_start !== wr_lcd) bad_rs++;
            if (wr_lcd === 1'b1) begin
                npulse++;
                n_vec++; if (k != 100 * npulse) begin n_err++; $display("FAIL normal_spacing: pulse %0d at cycle %0d want %0d", npulse, k, 100 * npulse); end
                n_vec++; if (dvsr !== 8'd6) begin n_err++; $display("FAIL normal_dvsr: got %0d want 6", dvsr); end
            end
        end
        enable = 1'b0;
        n_vec++; if (npulse != 5) begin n_err++; $display("FAIL normal_pulses: got %0d want 5", npulse); end
        n_vec++; if (bad_rs != 0) begin n_err++; $display("FAIL normal_reader_start: %0d cycles differ from wr_lcd, want 0", bad_rs); end
        n_vec++; if (frame_count !== 16'd5) begin n_err++; $display("FAIL normal_frame_count: got %0d want 5", frame_count); end
        n_vec++; if (skip_count !== 16'd0) begin n_err++; $display("FAIL normal_skip_count: got %0d want 0", skip_count); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL normal_timeout_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_swap();
        int bad;
        do_reset();
        bad = 0;
        dvsr_cfg = 8'd6; enable = 1'b1;
        for (int k = 1; k <= 310; k++) begin
            @(negedge clk);
            if (k >= 121 && k < 200 && front_base !== 32'h0) bad++;
            if (k == 100) begin
                n_vec++; if (wr_lcd !== 1'b1 || swap_ack !== 1'b0) begin n_err++; $display("FAIL swap_first_launch: got wr %b ack %b want 1/0", wr_lcd, swap_ack); end
            end
            if (k == 120) begin back_base = 32'h0010_0000; swap_req = 1'b1; end
            if (k == 121) swap_req = 1'b0;
            if (k == 200) begin
                n_vec++; if (wr_lcd !== 1'b1 || swap_ack !== 1'b1) begin n_err++; $display("FAIL swap_ack_launch: got wr %b ack %b want 1/1", wr_lcd, swap_ack); end
                n_vec++; if (front_base !== 32'h0010_0000) begin n_err++; $display("FAIL swap_front_base: got %h want 00100000", front_base); end
                back_base = 32'h0020_0000; swap_req = 1'b1;
            end
            if (k == 201) begin
                swap_req = 1'b0;
                n_vec++; if (swap_ack !== 1'b0 || front_base !== 32'h0010_0000) begin n_err++; $display("FAIL swap_in_launch_held: got ack %b base %h want 0/00100000", swap_ack, front_base); end
            end
            if (k == 300) begin
                n_vec++; if (wr_lcd !== 1'b1 || swap_ack !== 1'b1 || front_base !== 32'h0020_0000) begin n_err++; $display("FAIL swap_next_frame: got wr %b ack %b base %h want 1/1/00200000", wr_lcd, swap_ack, front_base); end
            end
        end
        enable = 1'b0;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL swap_mid_frame: front_base changed in %0d cycles, want 0", bad); end
    endtask

    task automatic test_overrun();
        int nwr;
        int bad;
        bit prev_busy;
        do_reset();
        nwr = 0; bad = 0; prev_busy = 1'b0;
        enable_b = 1'b1;
        for (int k = 1; k <= 660; k++) begin
            @(negedge clk);
            if (b_wr_lcd === 1'b1) begin
                nwr++;
                if (prev_busy) bad++;
                n_vec++; if (k != 100 + 200 * (nwr - 1)) begin n_err++; $display("FAIL overrun_launch_cycle: pulse %0d at %0d want %0d", nwr, k, 100 + 200 * (nwr - 1)); end
            end
            if (k == 200) begin
                n_vec++; if (b_skip_count !== 16'd1) begin n_err++; $display("FAIL overrun_first_skip: got %0d want 1", b_skip_count); end
            end
            prev_busy = b_busy;
        end
        enable_b = 1'b0;
        n_vec++; if (nwr != 3 || bad != 0) begin n_err++; $display("FAIL overrun_pulses: got %0d pulses, %0d while busy, want 3/0", nwr, bad); end
        n_vec++; if (b_frame_count !== 16'd3) begin n_err++; $display("FAIL overrun_frame_count: got %0d want 3", b_frame_count); end
        n_vec++; if (b_skip_count !== 16'd3) begin n_err++; $display("FAIL overrun_skip_count: got %0d want 3", b_skip_count); end
        n_vec++; if (b_timeout_err !== 1'b0) begin n_err++; $display("FAIL overrun_timeout_err: got %b want 0", b_timeout_err); end
    endtask

    task automatic test_stall();
        do_reset();
        ma_stall = 1'b1; dvsr_cfg = 8'd6; enable = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 100 || k == 200) begin
                n_vec++; if (wr_lcd !== 1'b1) begin n_err++; $display("FAIL stall_launch_%0d: got %b want 1", k, wr_lcd); end
            end
            if (k == 149 || k == 249) begin
                n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL stall_early_%0d: got %b want 0", k, timeout_err); end
            end
            if (k == 150 || k == 199) begin
                n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL stall_flag_%0d: got %b want 1", k, timeout_err); end
            end
            if (k == 210) err_clr = 1'b1;
            if (k == 211) begin
                err_clr = 1'b0;
                n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL stall_err_clr: got %b want 0", timeout_err); end
            end
            if (k == 250) begin
                n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL stall_second_timeout: got %b want 1", timeout_err); end
                err_clr = 1'b1;
            end
            if (k == 251) begin
                err_clr = 1'b0;
                n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL stall_set_wins: got %b want 1", timeout_err); end
            end
        end
        enable = 1'b0; ma_stall = 1'b0;
        n_vec++; if (frame_count !== 16'd0 || skip_count !== 16'd0) begin n_err++; $display("FAIL stall_counts: got frames %0d skips %0d want 0/0", frame_count, skip_count); end
    endtask

    task automatic test_init_clamp();
        int nwr;
        int nbusy;
        do_reset();
        nwr = 0; nbusy = 0;
        ma_low = 1'b1; dvsr_cfg = 8'd0; enable = 1'b1;
        for (int k = 1; k <= 360; k++) begin
            @(negedge clk);
            if (k <= 350) begin
                if (wr_lcd === 1'b1) nwr++;
                if (busy === 1'b1) nbusy++;
            end
            if (k == 300) begin
                n_vec++; if (skip_count !== 16'd2) begin n_err++; $display("FAIL init_skip_count: got %0d want 2", skip_count); end
                n_vec++; if (dvsr !== 8'd4) begin n_err++; $display("FAIL init_dvsr_before: got %0d want 4", dvsr); end
            end
            if (k == 350) ma_low = 1'b0;
            if (k == 351) begin
                n_vec++; if (wr_lcd !== 1'b1 || reader_start !== 1'b1) begin n_err++; $display("FAIL init_launch: got wr %b rs %b want 1/1", wr_lcd, reader_start); end
                n_vec++; if (dvsr !== 8'd2) begin n_err++; $display("FAIL init_dvsr_clamp: got %0d want 2", dvsr); end
            end
        end
        enable = 1'b0;
        n_vec++; if (nwr != 0 || nbusy != 0) begin n_err++; $display("FAIL init_hold: got %0d wr, %0d busy cycles, want 0/0", nwr, nbusy); end
    endtask

    task automatic test_enable_reset();
        int nwr;
        int first;
        do_reset();
        nwr = 0; first = -1;
        dvsr_cfg = 8'd6; enable = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 100) begin
                n_vec++; if (wr_lcd !== 1'b1) begin n_err++; $display("FAIL enable_launch: got %b want 1", wr_lcd); end
            end
            if (k > 100 && wr_lcd === 1'b1) nwr++;
            if (k == 120) enable = 1'b0;
            if (k == 140) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL enable_busy_in_flight: got %b want 1", busy); end
            end
            if (k == 144) begin
                n_vec++; if (busy !== 1'b0 || frame_count !== 16'd1) begin n_err++; $display("FAIL enable_complete: got busy %b frames %0d want 0/1", busy, frame_count); end
            end
        end
        n_vec++; if (nwr != 0) begin n_err++; $display("FAIL enable_no_relaunch: got %0d wr want 0", nwr); end
        dvsr_cfg = 8'd9; enable = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 10) begin back_base = 32'h0003_0000; swap_req = 1'b1; end
            if (k == 11) swap_req = 1'b0;
            if (k == 100) begin
                n_vec++; if (wr_lcd !== 1'b1 || dvsr !== 8'd9 || front_base !== 32'h0003_0000) begin n_err++; $display("FAIL prereset_launch: got wr %b dvsr %0d base %h want 1/9/00030000", wr_lcd, dvsr, front_base); end
            end
        end
        rst = 1'b1; enable = 1'b0;
        #1;
        n_vec++; if (dvsr !== 8'd4 || front_base !== 32'h0) begin n_err++; $display("FAIL midreset_regs: got dvsr %0d base %h want 4/0", dvsr, front_base); end
        n_vec++; if ({wr_lcd, reader_start, swap_ack, busy, timeout_err} !== 5'b0) begin n_err++; $display("FAIL midreset_flags: got %b want 00000", {wr_lcd, reader_start, swap_ack, busy, timeout_err}); end
        n_vec++; if (frame_count !== 16'd0 || skip_count !== 16'd0) begin n_err++; $display("FAIL midreset_counts: got %0d/%0d want 0/0", frame_count, skip_count); end
        repeat (3) @(negedge clk);
        n_vec++; if (wr_lcd !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midreset_hold: got wr %b busy %b want 0/0", wr_lcd, busy); end
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (wr_lcd === 1'b1 && first < 0) first = k;
        end
        enable = 1'b0;
        n_vec++; if (first != 100) begin n_err++; $display("FAIL postreset_first_launch: got cycle %0d want 100", first); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_swap();
        test_overrun();
        test_stall();
        test_init_clamp();
        test_enable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
